frame_difference_stream_join: RTL and testbench
===============================================

Name: frame_difference_stream_join

Overview:
- Front end of the frame-difference pipeline.
- Joins three AXI4-Stream YCbCr video inputs into one beat-aligned stream for the background/foreground/movement compute stage:
  - current frame, from the camera path;
  - previous frame, from the frame-buffer reader;
  - background frame, from the frame-buffer reader.
- Aligns the three inputs on start-of-frame (tuser) and checks line structure (tlast).
- On misalignment it drops beats and resynchronises, so compute never mixes pixels from different positions.

Parameters:
- TDATA_WIDTH, 24, pixel width (Y[23:16], Cb[15:8], Cr[7:0]), common to all streams.
- FRAME_WIDTH, 640, pixels per line; expected tlast position.
- CNT_WIDTH, 16, width of frame_count and err_count.

Ports:
- clk  in  1  single clock for the whole block.
- aresetn  in  1  asynchronous active-low reset.
- s_cur_tdata / s_prev_tdata / s_bg_tdata  in  TDATA_WIDTH each  input pixels.
- s_cur_tvalid / s_prev_tvalid / s_bg_tvalid  in  1 each.
- s_cur_tready / s_prev_tready / s_bg_tready  out  1 each.
- s_cur_tuser / s_prev_tuser / s_bg_tuser  in  1 each  start-of-frame.
- s_cur_tlast / s_prev_tlast / s_bg_tlast  in  1 each  end-of-line.
- m_cur_tdata / m_prev_tdata / m_bg_tdata  out  TDATA_WIDTH each  aligned output pixels.
- m_tvalid  out  1.
- m_tready  in  1.
- m_tuser  out  1.
- m_tlast  out  1.
- sync_err  out  1  one-cycle pulse per detected misalignment.
- frame_count  out  CNT_WIDTH  SOF beats emitted; wraps.
- err_count  out  CNT_WIDTH  sync_err pulses; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - all s_*_tready=0, m_tvalid=0, m_tuser=0, m_tlast=0, all m_*_tdata=0;
  - sync_err=0, frame_count=0, err_count=0;
  - pixel counter x=0, state=RESYNC, output buffer empty.
- Output stage: 2-entry skid buffer.
  - m_tvalid/m_t* driven from registers only.
  - No combinational path from m_tready to any s_*_tready.
  - Latency: joint input transfer -> m_tvalid is 1 cycle when the buffer is empty.
  - Order preserved; m_t* stable while m_tvalid=1 and m_tready=0.
- State RESYNC:
  - Per input, a beat with tuser=0 is drained: tready=1, beat discarded, never reaches output.
  - A beat with tuser=1 is held: that input's tready=0.
  - When all three hold tuser=1 and the buffer has a free entry: joint transfer (all three tready=1 in the same cycle), beat enters buffer with m_tuser=1, x updated per counter rule, state->RUN.
  - Draining is independent of m_tready.
- State RUN (join):
  - All three tready=1 in a cycle iff all three tvalid=1 and buffer not full; otherwise all three tready=0.
  - Partial transfers are forbidden.
- Per joint transfer, mismatch check. A mismatch is any of:
  - tuser values differ among the inputs;
  - tlast values differ among the inputs;
  - tuser=1 while x!=0;
  - agreed tlast=1 while x!=FRAME_WIDTH-1;
  - x==FRAME_WIDTH-1 with agreed tlast=0.
- On mismatch:
  - beat is consumed but not emitted;
  - sync_err=1 for one cycle; err_count+1 (saturating);
  - x=0; state->RESYNC.
  - The offending beat is not re-examined.
- Pixel counter x, on every emitted beat:
  - x = (tlast ? 0 : x+1);
  - an SOF beat sets x = (tlast ? 0 : 1).
- frame_count: +1 on each emitted beat with m_tuser=1 (counted at buffer entry); wraps modulo 2^CNT_WIDTH.
- Output flags: m_tuser / m_tlast carry the agreed input values.
- Backpressure:
  - m_tready=0 indefinitely -> buffer fills -> RUN tready=0;
  - RESYNC drain continues; held SOF beats wait.
- Simultaneous events: a mismatch in the same cycle as m_tready handshake of an older beat -> the older beat completes normally; only the new beat is dropped.
- Reset mid-frame: buffer contents lost; resync at the next common tuser.

Test Plan:
1. Aligned streams, FRAME_WIDTH=4, 2 frames x 2 lines, m_tready=1 -> 16 beats out, m_tuser on beats 0 and 8, m_tlast on beats 3,7,11,15, m_tdata = inputs 1 cycle later, frame_count=2, err_count=0.
2. Background stream starts 3 beats mid-frame before its SOF, others start at SOF -> 3 bg beats drained, first output beat has all three pixels from SOF, no sync_err.
3. prev stream tlast at pixel 2 (FRAME_WIDTH=4) -> one sync_err pulse, err_count=1, mismatching beat absent from output, output resumes at next common SOF with m_tuser=1.
4. Random m_tready (50%) with continuous inputs -> no beat lost or duplicated, m_t* stable while stalled, s_*_tready never asserted separately.
5. m_tready=0 for 10 cycles -> exactly 2 beats buffered, all s_*_tready=0 afterwards; release -> beats out in order.
6. aresetn pulsed low mid-line -> all outputs 0 immediately, counters 0, state RESYNC; following frames align correctly.

Source files
------------

// File: rtl/frame_difference_stream_join.sv
// Joins current/previous/background YCbCr AXI4-Stream inputs into one
// beat-aligned stream, resynchronising on SOF (tuser) after any misalignment.
//
// Ports:
//   clk, aresetn                 clock, async active-low reset
//   s_{cur,prev,bg}_t*           three AXI4-Stream video inputs
//   m_{cur,prev,bg}_tdata, m_t*  joined output stream (registered)
//   sync_err                     one-cycle pulse per dropped misaligned beat
//   frame_count                  SOF beats emitted (wraps)
//   err_count                    sync_err pulses (saturates)
module frame_difference_stream_join #(
   parameter int TDATA_WIDTH = 24,
   parameter int FRAME_WIDTH = 640,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic [TDATA_WIDTH-1:0] s_cur_tdata,
   input  logic                   s_cur_tvalid,
   output logic                   s_cur_tready,
   input  logic                   s_cur_tuser,
   input  logic                   s_cur_tlast,
   input  logic [TDATA_WIDTH-1:0] s_prev_tdata,
   input  logic                   s_prev_tvalid,
   output logic                   s_prev_tready,
   input  logic                   s_prev_tuser,
   input  logic                   s_prev_tlast,
   input  logic [TDATA_WIDTH-1:0] s_bg_tdata,
   input  logic                   s_bg_tvalid,
   output logic                   s_bg_tready,
   input  logic                   s_bg_tuser,
   input  logic                   s_bg_tlast,
   output logic [TDATA_WIDTH-1:0] m_cur_tdata,
   output logic [TDATA_WIDTH-1:0] m_prev_tdata,
   output logic [TDATA_WIDTH-1:0] m_bg_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tuser,
   output logic                   m_tlast,
   output logic                   sync_err,
   output logic [CNT_WIDTH-1:0]   frame_count,
   output logic [CNT_WIDTH-1:0]   err_count
);

   localparam int XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);

   typedef enum logic {RESYNC, RUN} state_e;

   typedef struct packed {
      logic                   user;
      logic                   last;
      logic [TDATA_WIDTH-1:0] cur;
      logic [TDATA_WIDTH-1:0] prev;
      logic [TDATA_WIDTH-1:0] bg;
   } beat_t;

   state_e               state_q, state_d;
   logic [XW-1:0]        x_q, x_d;
   logic                 en_q, en_d;
   beat_t                out_q, out_d;
   logic                 out_vld_q, out_vld_d;
   beat_t                skid_q, skid_d;
   logic                 skid_vld_q, skid_vld_d;
   logic                 sync_err_q, sync_err_d;
   logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   logic  all_valid;
   logic  all_sof;
   logic  free;
   logic  pop;
   logic  joint;
   logic  push;
   logic  mm;
   beat_t in_beat;

   // en_q keeps all tready low until the first clock after reset release
   always_comb begin
      all_valid = s_cur_tvalid & s_prev_tvalid & s_bg_tvalid;
      all_sof   = s_cur_tuser & s_prev_tuser & s_bg_tuser;
      // Fullness comes only from registers: no m_tready -> s_tready path
      free      = ~(out_vld_q & skid_vld_q);
      pop       = out_vld_q & m_tready;
      joint     = en_q & all_valid & free &
                  ((state_q == RUN) | all_sof);
      in_beat   = '{user: s_cur_tuser,
                    last: s_cur_tlast,
                    cur:  s_cur_tdata,
                    prev: s_prev_tdata,
                    bg:   s_bg_tdata};
      mm = (s_cur_tuser != s_prev_tuser) |
           (s_cur_tuser != s_bg_tuser) |
           (s_cur_tlast != s_prev_tlast) |
           (s_cur_tlast != s_bg_tlast) |
           (s_cur_tuser & (x_q != '0)) |
           (s_cur_tlast & (x_q != X_LAST)) |
           (~s_cur_tlast & (x_q == X_LAST));
      push = joint & ~mm;
   end

   // Resync drains non-SOF beats per input; SOF beats wait for the join
   always_comb begin
      s_cur_tready  = joint | (en_q & (state_q == RESYNC) &
                               s_cur_tvalid & ~s_cur_tuser);
      s_prev_tready = joint | (en_q & (state_q == RESYNC) &
                               s_prev_tvalid & ~s_prev_tuser);
      s_bg_tready   = joint | (en_q & (state_q == RESYNC) &
                               s_bg_tvalid & ~s_bg_tuser);
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      en_d        = 1'b1;
      sync_err_d  = 1'b0;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (joint) begin
         if (mm) begin
            sync_err_d = 1'b1;
            if (err_cnt_q != '1)
               err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            x_d     = '0;
            state_d = RESYNC;
         end else begin
            x_d     = s_cur_tlast ? '0 : x_q + XW'(1);
            state_d = RUN;
            if (s_cur_tuser)
               frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // Two-entry skid buffer: out_q is the head, skid_q the second slot
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (pop) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end else if (push) begin
            out_d = in_beat;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (push) begin
         if (!out_vld_q) begin
            out_d     = in_beat;
            out_vld_d = 1'b1;
         end else begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= RESYNC;
         x_q         <= '0;
         en_q        <= 1'b0;
         out_q       <= '0;
         out_vld_q   <= 1'b0;
         skid_q      <= '0;
         skid_vld_q  <= 1'b0;
         sync_err_q  <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         en_q        <= en_d;
         out_q       <= out_d;
         out_vld_q   <= out_vld_d;
         skid_q      <= skid_d;
         skid_vld_q  <= skid_vld_d;
         sync_err_q  <= sync_err_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign m_cur_tdata  = out_q.cur;
   assign m_prev_tdata = out_q.prev;
   assign m_bg_tdata   = out_q.bg;
   assign m_tvalid     = out_vld_q;
   assign m_tuser      = out_q.user;
   assign m_tlast      = out_q.last;
   assign sync_err     = sync_err_q;
   assign frame_count  = frame_cnt_q;
   assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_frame_difference_stream_join.sv
// Scoreboard bench for frame_difference_stream_join (FRAME_WIDTH=4).
// Stream drivers and output monitor run as independent processes.
module tb_frame_difference_stream_join;

   typedef struct packed {
      logic [23:0] d;
      logic        u;
      logic        l;
   } sbeat_t;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [23:0] td [3];
   logic [2:0]  tv, tu, tl, tr;
   logic [23:0] m_cur, m_prev, m_bg;
   logic        m_tvalid, m_tready, m_tuser, m_tlast, sync_err;
   logic [15:0] frame_count, err_count;

   sbeat_t      sq [3][$];
   logic [73:0] exp_q [$];
   int          acc [3];
   int          n_run = 0;
   int          n_fail = 0;
   int          pulses = 0;
   int          mode = 0;
   bit          sb_off = 0;
   bit          chk_rdy = 0;

   always #5 clk = ~clk;

   frame_difference_stream_join #(
      .TDATA_WIDTH(24), .FRAME_WIDTH(4), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .aresetn(aresetn),
      .s_cur_tdata(td[0]), .s_cur_tvalid(tv[0]), .s_cur_tready(tr[0]),
      .s_cur_tuser(tu[0]), .s_cur_tlast(tl[0]),
      .s_prev_tdata(td[1]), .s_prev_tvalid(tv[1]), .s_prev_tready(tr[1]),
      .s_prev_tuser(tu[1]), .s_prev_tlast(tl[1]),
      .s_bg_tdata(td[2]), .s_bg_tvalid(tv[2]), .s_bg_tready(tr[2]),
      .s_bg_tuser(tu[2]), .s_bg_tlast(tl[2]),
      .m_cur_tdata(m_cur), .m_prev_tdata(m_prev), .m_bg_tdata(m_bg),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tuser(m_tuser), .m_tlast(m_tlast),
      .sync_err(sync_err), .frame_count(frame_count),
      .err_count(err_count)
   );

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] req);
      n_run++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic logic [23:0] pix(input int s, input int f,
                                       input int i);
      return {8'(s + 1), 8'(f), 8'(i)};
   endfunction

   // Two lines of four pixels; bad_last forces an early tlast
   task automatic add_frame(input int s, input int f, input int bad_last);
      sbeat_t b;
      for (int i = 0; i < 8; i++) begin
         b.d = pix(s, f, i);
         b.u = (i == 0);
         b.l = (i % 4 == 3) || (i == bad_last);
         sq[s].push_back(b);
      end
   endtask

   task automatic add_exp(input int f, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({(i == 0), (i % 4 == 3),
                          pix(0, f, i), pix(1, f, i), pix(2, f, i)});
   endtask

   task automatic add_all(input int f);
      for (int s = 0; s < 3; s++) add_frame(s, f, -1);
      add_exp(f, 8);
   endtask

   task automatic wait_done(input string nm, input int budget);
      int t = 0;
      while ((sq[0].size() + sq[1].size() + sq[2].size() +
              exp_q.size()) != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_drain"}, sq[0].size() + sq[1].size() + sq[2].size() +
          exp_q.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic chk_counts(input string nm, input int fc, input int ec,
                             input int np);
      chk({nm, "_frame_count"}, frame_count, fc);
      chk({nm, "_err_count"}, err_count, ec);
      chk({nm, "_sync_pulses"}, pulses, np);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, "_tready"}, tr, 0);
      chk({nm, "_mflags"}, {m_tvalid, m_tuser, m_tlast, sync_err}, 0);
      chk({nm, "_mdata"}, {m_cur, m_prev, m_bg}, 0);
      chk({nm, "_counts"}, {frame_count, err_count}, 0);
   endtask

   // Stream drivers: present head beat, pop it once handshaken
   initial begin
      tv = '0; tu = '0; tl = '0;
      for (int s = 0; s < 3; s++) td[s] = '0;
      forever begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            if (sq[s].size() > 0) begin
               tv[s] = 1'b1;
               td[s] = sq[s][0].d;
               tu[s] = sq[s][0].u;
               tl[s] = sq[s][0].l;
            end else begin
               tv[s] = 1'b0;
               td[s] = '0;
               tu[s] = 1'b0;
               tl[s] = 1'b0;
            end
         end
         #4;
         for (int s = 0; s < 3; s++)
            if (tv[s] && tr[s]) begin
               void'(sq[s].pop_front());
               acc[s]++;
            end
      end
   end

   // Output monitor: scoreboard compare, stall stability, sync pulses
   initial begin
      logic [73:0] held;
      bit          stalled;
      stalled  = 0;
      held     = '0;
      m_tready = 1'b0;
      forever begin
         @(negedge clk);
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
         endcase
         #4;
         if (chk_rdy)
            chk("tready_joint", {tr[1], tr[2]}, {tr[0], tr[0]});
         if (stalled && m_tvalid)
            chk("stall_stable", {m_tuser, m_tlast, m_cur, m_prev, m_bg},
                held);
         if (m_tvalid && m_tready && !sb_off) begin
            if (exp_q.size() == 0)
               chk("unexpected_beat", {m_tuser, m_tlast, m_cur}, 0);
            else
               chk("beat", {m_tuser, m_tlast, m_cur, m_prev, m_bg},
                   exp_q.pop_front());
         end
         stalled = m_tvalid && !m_tready;
         held    = {m_tuser, m_tlast, m_cur, m_prev, m_bg};
         if (sync_err) pulses++;
      end
   end

   initial begin
      for (int s = 0; s < 3; s++) acc[s] = 0;
      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      #2 aresetn = 1'b1;
      @(negedge clk);

      // bg starts three beats into a frame; those get drained
      begin
         sbeat_t b;
         for (int i = 1; i < 4; i++) begin
            b.d = pix(2, 9, i);
            b.u = 1'b0;
            b.l = (i == 3);
            sq[2].push_back(b);
         end
      end
      add_all(1);
      wait_done("bg_late", 300);
      chk_counts("bg_late", 1, 0, 0);

      // two aligned frames
      chk_rdy = 1;
      add_all(2);
      add_all(3);
      wait_done("aligned", 300);
      chk_counts("aligned", 3, 0, 0);
      chk_rdy = 0;

      // prev ends a line early at pixel 2
      add_frame(0, 4, -1);
      add_frame(1, 4, 2);
      add_frame(2, 4, -1);
      add_exp(4, 2);
      add_all(5);
      wait_done("early_last", 300);
      chk_counts("early_last", 5, 1, 1);

      // random output backpressure
      chk_rdy = 1;
      mode = 1;
      add_all(6);
      add_all(7);
      add_all(8);
      wait_done("rand_ready", 600);
      chk_counts("rand_ready", 8, 1, 1);

      // hold m_tready low: exactly two beats fit
      mode = 2;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) acc[s] = 0;
      add_all(9);
      repeat (10) @(negedge clk);
      #4;
      chk("stall_accepts", {acc[0], acc[1], acc[2]}, {32'd2, 32'd2, 32'd2});
      chk("stall_tready", tr, 0);
      chk("stall_head", {m_tvalid, m_tuser, m_cur},
          {1'b1, 1'b1, pix(0, 9, 0)});
      mode = 0;
      wait_done("stall", 300);
      chk_rdy = 0;
      chk_counts("stall", 9, 1, 1);

      // reset in the middle of line 1 of frame 10
      sb_off = 1;
      for (int s = 0; s < 3; s++) acc[s] = 0;
      add_frame(0, 10, -1);
      add_frame(1, 10, -1);
      add_frame(2, 10, -1);
      begin
         int t = 0;
         while (acc[0] < 5 && t < 100) begin
            @(negedge clk);
            t++;
         end
         chk("midline_reach", acc[0] >= 5, 1);
      end
      @(negedge clk);
      #2 aresetn = 1'b0;
      #1;
      chk_reset_state("midline_reset");
      @(negedge clk);
      #2 aresetn = 1'b1;
      @(negedge clk);
      sb_off = 0;
      pulses = 0;
      add_all(11);
      wait_done("after_reset", 300);
      chk_counts("after_reset", 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
